writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 175 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Merges single-cycle pipeline writebacks with long-latency (LSU) results
// onto the one register-file write port. Long-latency results queue in a
// small FIFO. Pipeline writes normally win. A starvation counter raises
// stall_req so the pipeline gives the FIFO a turn.
module writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_rd,
    input  logic [31:0]              pipe_wd,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [31:0]              lsu_wd,
    output logic                     WE3,
    output logic [4:0]               A3,
    output logic [31:0]              WD3,
    input  logic [4:0]               chk_addr,
    output logic                     chk_hit,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    // FIFO storage. It is kept as registers because every occupied entry is
    // compared against chk_addr in the same cycle.
    logic [4:0]    mem_rd_q [DEPTH];
    logic [31:0]   mem_wd_q [DEPTH];

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          we3_q, we3_d;
    logic [4:0]    a3_q, a3_d;
    logic [31:0]   wd3_q, wd3_d;

    logic          pipe_valid;
    logic          fifo_nonempty;
    logic          lsu_accept;
    logic          push;
    logic          pop;
    logic          sel_pipe;
    logic [DEPTH-1:0] entry_hit;

    // Qualify the incoming requests. Writes to x0 are never real writes.
    always_comb begin
        pipe_valid    = pipe_we && (pipe_rd != 5'd0);
        fifo_nonempty = (count_q != '0);
        lsu_ready     = rst && (count_q < DEPTH_C);
        lsu_accept    = lsu_valid && lsu_ready;
        push          = lsu_accept && (lsu_rd != 5'd0);
    end

    // Arbitration between the pipeline and the FIFO head.
    // While stalling, the pipeline is expected to hold off, so the FIFO drains.
    // If the pipeline still writes, its data has nowhere else to go.
    // In that case the pipe write takes the port and the FIFO waits, so no data is dropped.
    always_comb begin
        sel_pipe = 1'b0;
        pop      = 1'b0;
        if (stall_q && fifo_nonempty && !pipe_valid) begin
            pop = 1'b1;
        end else if (pipe_valid) begin
            sel_pipe = 1'b1;
        end else if (fifo_nonempty) begin
            pop = 1'b1;
        end
    end

    // Next-state for the output register, pointers, occupancy and starvation.
    always_comb begin
        we3_d    = 1'b0;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        starve_d = starve_q;

        if (sel_pipe) begin
            we3_d = 1'b1;
            a3_d  = pipe_rd;
            wd3_d = pipe_wd;
        end else if (pop) begin
            we3_d = 1'b1;
            a3_d  = mem_rd_q[rptr_q];
            wd3_d = mem_wd_q[rptr_q];
        end

        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The counter measures how long the head has waited behind pipe writes.
        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (sel_pipe && (starve_q != STARVE_C)) begin
            starve_d = starve_q + SW'(1);
        end

        stall_d = (starve_d == STARVE_C);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we3_q    <= 1'b0;
            a3_q     <= 5'd0;
            wd3_q    <= 32'd0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
        end
    end

    // FIFO payload write. Contents need no reset because the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wptr_q] <= lsu_rd;
            mem_wd_q[wptr_q] <= lsu_wd;
        end
    end

    // Per-entry hazard match. An entry counts only if its offset from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [AW-1:0] offset;
            assign offset        = AW'(gi) - rptr_q;
            assign entry_hit[gi] = ({1'b0, offset} < count_q) && (mem_rd_q[gi] == chk_addr);
        end
    endgenerate

    // A register is still pending if it is queued or is being written this cycle.
    always_comb begin
        chk_hit = (chk_addr != 5'd0) && ((|entry_hit) || (we3_q && (a3_q == chk_addr)));
    end

    assign WE3       = we3_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign stall_req = stall_q;
    assign count     = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter.
// The stimulus process updates a queue-based reference model and pushes the
// expected register-file writes. A negedge monitor pops them as WE3 appears.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wd;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  chk_addr;
    logic        chk_hit;
    logic        stall_req;
    logic [2:0]  count;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .chk_addr(chk_addr), .chk_hit(chk_hit),
        .stall_req(stall_req), .count(count)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected writes {rd, wd}, in the order they must appear.
    logic [36:0] exp_q[$];

    // Reference model: pending long-latency results plus starvation bookkeeping.
    logic [4:0]  m_rd[$];
    logic [31:0] m_wd[$];
    int          m_starve = 0;
    bit          m_stall  = 1'b0;
    bit          m_we     = 1'b0;
    logic [4:0]  m_a3     = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic bit model_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (m_rd[i]) if (m_rd[i] == a) return 1'b1;
        return m_we && (m_a3 == a);
    endfunction

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (WE3) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got a3=%0d wd=%h want no write", A3, WD3);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({A3, WD3} !== e) begin
                    bad++;
                    $display("FAIL wb_data: got a3=%0d wd=%h want a3=%0d wd=%h",
                             A3, WD3, e[36:32], e[31:0]);
                end else begin
                    $display("write a3=%0d wd=%h", A3, WD3);
                end
            end
        end
    end

    // One clock of stimulus: apply inputs, check the current state against the model,
    // advance the model across the coming edge, then wait for that edge.
    task automatic cycle(input bit pw, input logic [4:0] prd, input logic [31:0] pwd,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] lwd,
                         input logic [4:0] ca);
        bit pv;
        bit ne;
        bit acc;
        bit popd;
        pipe_we   = pw;
        pipe_rd   = prd;
        pipe_wd   = pwd;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_wd    = lwd;
        chk_addr  = ca;
        #1;
        chk("count", 32'(count), 32'(m_rd.size()));
        chk("lsu_ready", 32'(lsu_ready), 32'(m_rd.size() < DEPTH));
        chk("stall_req", 32'(stall_req), 32'(m_stall));
        chk("chk_hit", 32'(chk_hit), 32'(model_hit(ca)));

        pv   = pw && (prd != 5'd0);
        ne   = (m_rd.size() > 0);
        acc  = lv && (m_rd.size() < DEPTH);
        popd = 1'b0;
        // Pipeline writes always take the port; otherwise the oldest queued result drains.
        if (pv) begin
            exp_q.push_back({prd, pwd});
            m_we = 1'b1;
            m_a3 = prd;
        end else if (ne) begin
            exp_q.push_back({m_rd[0], m_wd[0]});
            m_we = 1'b1;
            m_a3 = m_rd[0];
            void'(m_rd.pop_front());
            void'(m_wd.pop_front());
            popd = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (!ne || popd) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        m_stall = (m_starve == SMAX);
        if (acc && (lrd != 5'd0)) begin
            m_rd.push_back(lrd);
            m_wd.push_back(lwd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_rd.delete();
        m_wd.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_we     = 1'b0;
        m_a3     = 5'd0;
    endtask

    task automatic set_idle_inputs();
        pipe_we   = 1'b0;
        pipe_rd   = 5'd0;
        pipe_wd   = 32'd0;
        lsu_valid = 1'b0;
        lsu_rd    = 5'd0;
        lsu_wd    = 32'd0;
        chk_addr  = 5'd0;
    endtask

    // Reset asserted in the middle of a clock period: outputs must clear at once.
    task automatic mid_reset();
        #2;
        set_idle_inputs();
        rst = 1'b0;
        #1;
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("init_we3", 32'(WE3), 32'd0);
        chk("init_count", 32'(count), 32'd0);
        chk("init_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("init_stall", 32'(stall_req), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Pipe-only writes; a write to x0 must not appear.
        cycle(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 5'd5);
        cycle(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 5'd5);
        idle(2);

        // Long-latency results drain in arrival order.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, 5'd3);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 5'd4);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h33, 5'd7);
        idle(4);

        // An LSU result to x0 is consumed and dropped.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0);
        idle(2);

        // Fill while the pipe is busy; the fifth result waits for space.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(20 + i), 32'(32'hB0 + i), 5'(20 + i));
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd25, 32'hFF, 5'd0);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd25, 32'hFF, 5'd25);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 32'hFF, 5'd25);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 32'hFF, 5'd25);
        idle(8);

        // Starvation: one entry waits behind pipe writes until stall_req rises.
        // The last pipe write arrives during the stall and must still win.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 5'd12);
        for (int i = 0; i < SMAX + 1; i++)
            cycle(1'b1, 5'(2 + i), 32'(32'h100 + i), 1'b0, 5'd0, 32'd0, 5'd12);
        idle(3);

        // Hazard query follows the queued entry and then its write cycle.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9);
        cycle(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0, 5'd9);
        cycle(1'b1, 5'd3, 32'h4, 1'b0, 5'd0, 32'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);

        // Asynchronous reset with three results queued.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'd1, 32'(i), 1'b1, 5'(14 + i), 32'(32'hE0 + i), 5'd0);
        chk("pre_rst_count", 32'(count), 32'd3);
        mid_reset();
        idle(3);

        // Random traffic: a pipe-heavy phase (starvation) then a lighter phase.
        for (int i = 0; i < 500; i++) begin
            int pw_pct;
            pw_pct = (i < 250) ? 8 : 3;
            cycle($urandom_range(0, 9) < pw_pct,
                  5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)));
        end

        idle(20);
        @(negedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
